instr_fetch_unit: RTL

//  Fetch stage directly upstream of the instruction controller: owns the PC, issues

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: widths, FSM state and FIFO entry.
// Latency: none (type and constant definitions only).
// Backpressure: not applicable.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush, occupancy count and full/empty flags.
// Latency: a push is visible at pop_dat the cycle after it is written.
// Backpressure: push is ignored when full unless a pop frees a slot the same cycle.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [63:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output T                       pop_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues IMEM word reads, buffers returns with their PC tags.
// Latency: grant at T, rvalid at T+1, instr_valid at T+2; 1 instr/cycle sustained.
// Backpressure: requests are credit-limited so FIFO entries plus reads in flight never exceed DEPTH.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic              gnt, rv, redirect, push, pop;
  logic [CW-1:0]     fifo_count, tag_count;
  logic              fifo_full, fifo_empty, tag_full, tag_empty;
  logic [ADDR_W-1:0] tag_head;
  fetch_entry_t      push_entry, head;

  // A return with nothing outstanding is a leftover from before reset and is ignored.
  assign rv          = imem_rvalid && (out_q != '0);
  assign redirect    = br_taken && (state_q != BOOT);
  assign imem_req    = (state_q == RUN) && !br_taken &&
                       (({1'b0, fifo_count} + {1'b0, out_q}) < DEPTH_C);
  assign gnt         = imem_req && imem_gnt;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == RUN) && !fifo_empty;
  assign pop         = instr_valid && instr_ready;
  assign push        = (state_q == RUN) && rv && !redirect;
  assign push_entry  = '{instr: imem_rdata, pc: tag_head};
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;

  always_comb begin
    out_d = out_q;
    if (gnt && !rv) begin
      out_d = out_q + 1'b1;
    end else if (!gnt && rv) begin
      out_d = out_q - 1'b1;
    end

    pc_d = pc_q;
    if (redirect) begin
      pc_d = {br_target[ADDR_W-1:2], 2'b00};
    end else if (gnt) begin
      pc_d = pc_q + ADDR_W'(4);
    end

    // Reads still in flight after a redirect belong to the abandoned path.
    drop_d = drop_q;
    if (redirect) begin
      drop_d = out_d;
    end else if ((state_q == FLUSH) && rv && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end

    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redirect && (out_d != '0)) state_d = FLUSH;
      FLUSH:   if (drop_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_data_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .flush    (redirect),
    .pop_dat  (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Issue addresses in flight; popped by every return, kept or dropped.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (logic [ADDR_W-1:0])
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (gnt),
    .push_dat (pc_q),
    .pop      (rv),
    .flush    (1'b0),
    .pop_dat  (tag_head),
    .count    (tag_count),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));
  assert property (@(posedge clk) disable iff (!rst_n)
                   (tag_count == out_q) && (tag_empty == (out_q == '0)) && !(gnt && tag_full));

endmodule
